// File: rtl/bc_pkg.sv
// Shared encodings for the sequential base converter: op modes, FSM states,
// seven-segment constants and the hex glyph table.
package bc_pkg;

  typedef enum logic [2:0] {
    OP_UHEX = 3'b000,
    OP_UOCT = 3'b001,
    OP_SHEX = 3'b010,
    OP_SOCT = 3'b011,
    OP_UDEC = 3'b100,
    OP_SDEC = 3'b101
  } op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CONV = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  localparam logic [7:0] SEG_BLANK = 8'hFF;
  localparam logic [7:0] SEG_MINUS = 8'hBF;
  localparam logic [7:0] SEG_E     = 8'h86;

  // Reserved codes 11x fall back to unsigned hex.
  function automatic op_e op_decode(input logic [2:0] op);
    case (op)
      3'b001:  return OP_UOCT;
      3'b010:  return OP_SHEX;
      3'b011:  return OP_SOCT;
      3'b100:  return OP_UDEC;
      3'b101:  return OP_SDEC;
      default: return OP_UHEX;
    endcase
  endfunction

  function automatic logic op_is_dec(input op_e o);
    return (o == OP_UDEC) || (o == OP_SDEC);
  endfunction

  function automatic logic op_is_signed(input op_e o);
    return (o == OP_SHEX) || (o == OP_SOCT) || (o == OP_SDEC);
  endfunction

  function automatic logic op_is_oct(input op_e o);
    return (o == OP_UOCT) || (o == OP_SOCT);
  endfunction

  // Active-low a..g in bits 0..6, DP (bit 7) always off.
  function automatic logic [7:0] seg_glyph(input logic [3:0] d);
    case (d)
      4'h0: return 8'hC0;
      4'h1: return 8'hF9;
      4'h2: return 8'hA4;
      4'h3: return 8'hB0;
      4'h4: return 8'h99;
      4'h5: return 8'h92;
      4'h6: return 8'h82;
      4'h7: return 8'hF8;
      4'h8: return 8'h80;
      4'h9: return 8'h90;
      4'hA: return 8'h88;
      4'hB: return 8'h83;
      4'hC: return 8'hC6;
      4'hD: return 8'hA1;
      4'hE: return 8'h86;
      default: return 8'h8E;
    endcase
  endfunction

endpackage

// File: rtl/bc_seq_conv_if.sv
// Request/result bundle between the input source (master) and the converter (slave).
interface bc_seq_conv_if
  import bc_pkg::*;
#(
  parameter int N      = 10,
  parameter int DIGITS = 4
);

  // Handshake: start is honoured only while the converter is idle (busy=0 and
  // done=0); B_in/op are captured on that edge. busy stays high for the whole
  // conversion, done pulses for one cycle when HEX/overflow take the new result,
  // and starts seen while busy or done are dropped, not queued.
  logic                start;
  logic [N-1:0]        B_in;
  logic [2:0]          op;
  logic [8*DIGITS-1:0] HEX;
  logic                busy;
  logic                done;
  logic                overflow;
  state_e              state_dbg;

  modport master (
    output start, B_in, op,
    input  HEX, busy, done, overflow, state_dbg
  );

  modport slave (
    input  start, B_in, op,
    output HEX, busy, done, overflow, state_dbg
  );

endinterface

// File: rtl/bc_seg7_enc.sv
// One digit of the display: 4-bit value to active-low seven-segment pattern.
module bc_seg7_enc
  import bc_pkg::*;
(
  input  logic [3:0] digit,
  output logic [7:0] seg
);

  assign seg = seg_glyph(digit);

endmodule

// File: rtl/bc_seq_conv.sv
// Sequential hex/octal/decimal converter driving DIGITS seven-segment displays.
// Optional macro BC_LEADING_ZERO_BLANK_EN blanks leading zero digits.
module bc_seq_conv
  import bc_pkg::*;
#(
  parameter int N      = 10,
  parameter int DIGITS = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  bc_seq_conv_if.slave  bus
);

  localparam int BW = 4 * (DIGITS + 1);
  localparam int DW = 4 * DIGITS;
  localparam int CW = $clog2(N + DIGITS + 3);

  state_e              state_q, state_d;
  logic [CW-1:0]       cnt_q, cnt_d;
  logic [N-1:0]        braw_q, braw_d;
  logic [N-1:0]        mag_q, mag_d;
  op_e                 op_q, op_d;
  logic                neg_q, neg_d;
  logic                ovf_q, ovf_d;
  logic                ovf_out_q, ovf_out_d;
  logic [DW-1:0]       dig_q, dig_d;
  logic [BW-1:0]       bcd_q, bcd_d;
  logic [8*DIGITS-1:0] hex_q, hex_d;

  logic                is_dec, is_sgn, is_oct;
  int                  avail;
  logic [CW-1:0]       k_last;
  logic [N-1:0]        mag_load;
  logic                load_ovf;
  logic                dec_ovf;
  logic [BW-1:0]       bcd_adj;
  logic [3:0]          fin_dig [DIGITS];
  logic [7:0]          fin_seg [DIGITS];
  logic [8*DIGITS-1:0] disp;

  always_comb begin
    is_dec = op_is_dec(op_q);
    is_sgn = op_is_signed(op_q);
    is_oct = op_is_oct(op_q);
    avail  = is_sgn ? DIGITS - 1 : DIGITS;
    k_last = is_dec ? CW'(N + 1) : CW'(DIGITS + 1);
  end

  // Hex/oct overflow is known up front: any magnitude bit past the shown digits.
  always_comb begin
    mag_load = (is_sgn && braw_q[N-1]) ? N'(~braw_q + N'(1)) : braw_q;
    load_ovf = 1'b0;
    for (int i = 0; i < N; i++) begin
      if ((i >= avail * (is_oct ? 3 : 4)) && mag_load[i]) load_ovf = 1'b1;
    end
  end

  always_comb begin
    bcd_adj = bcd_q;
    for (int j = 0; j <= DIGITS; j++) begin
      if (bcd_q[4*j +: 4] >= 4'd5) bcd_adj[4*j +: 4] = bcd_q[4*j +: 4] + 4'd3;
    end
  end

  always_comb begin
    dec_ovf = 1'b0;
    for (int j = 0; j <= DIGITS; j++) begin
      if ((j >= avail) && (bcd_q[4*j +: 4] != 4'd0)) dec_ovf = 1'b1;
    end
    for (int k = 0; k < DIGITS; k++) begin
      fin_dig[k] = is_dec ? bcd_q[4*k +: 4] : dig_q[4*k +: 4];
    end
  end

  for (genvar g = 0; g < DIGITS; g++) begin : g_enc
    bc_seg7_enc u_enc (
      .digit (fin_dig[g]),
      .seg   (fin_seg[g])
    );
  end

  always_comb begin
`ifdef BC_LEADING_ZERO_BLANK_EN
    logic lead;
`endif
    for (int k = 0; k < DIGITS; k++) disp[8*k +: 8] = fin_seg[k];
    if (is_sgn) disp[8*(DIGITS-1) +: 8] = neg_q ? SEG_MINUS : SEG_BLANK;
`ifdef BC_LEADING_ZERO_BLANK_EN
    lead = 1'b1;
    for (int k = DIGITS - 1; k >= 1; k--) begin
      if (k < avail) begin
        lead = lead & (fin_dig[k] == 4'd0);
        if (lead) disp[8*k +: 8] = SEG_BLANK;
      end
    end
`endif
    if (ovf_q || (is_dec && dec_ovf)) disp = {DIGITS{SEG_E}};
  end

  // cnt 0 loads the magnitude, 1..K step one digit or one dabble shift,
  // K+1 renders the display so HEX only moves on entry to DONE.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    braw_d    = braw_q;
    mag_d     = mag_q;
    op_d      = op_q;
    neg_d     = neg_q;
    ovf_d     = ovf_q;
    ovf_out_d = ovf_out_q;
    dig_d     = dig_q;
    bcd_d     = bcd_q;
    hex_d     = hex_q;
    case (state_q)
      ST_IDLE: begin
        if (bus.start) begin
          braw_d  = bus.B_in;
          op_d    = op_decode(bus.op);
          cnt_d   = '0;
          state_d = ST_CONV;
        end
      end
      ST_CONV: begin
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == '0) begin
          neg_d = is_sgn & braw_q[N-1];
          mag_d = mag_load;
          dig_d = '0;
          bcd_d = '0;
          ovf_d = is_dec ? 1'b0 : load_ovf;
        end else if (cnt_q != k_last) begin
          if (is_dec) begin
            ovf_d = ovf_q | bcd_adj[BW-1];
            bcd_d = {bcd_adj[BW-2:0], mag_q[N-1]};
            mag_d = {mag_q[N-2:0], 1'b0};
          end else if (is_oct) begin
            dig_d = {1'b0, mag_q[2:0], dig_q[DW-1:4]};
            mag_d = mag_q >> 3;
          end else begin
            dig_d = {mag_q[3:0], dig_q[DW-1:4]};
            mag_d = mag_q >> 4;
          end
        end else begin
          hex_d     = disp;
          ovf_out_d = ovf_q | (is_dec & dec_ovf);
          state_d   = ST_DONE;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      braw_q    <= '0;
      mag_q     <= '0;
      op_q      <= OP_UHEX;
      neg_q     <= 1'b0;
      ovf_q     <= 1'b0;
      ovf_out_q <= 1'b0;
      dig_q     <= '0;
      bcd_q     <= '0;
      hex_q     <= {DIGITS{SEG_BLANK}};
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      braw_q    <= braw_d;
      mag_q     <= mag_d;
      op_q      <= op_d;
      neg_q     <= neg_d;
      ovf_q     <= ovf_d;
      ovf_out_q <= ovf_out_d;
      dig_q     <= dig_d;
      bcd_q     <= bcd_d;
      hex_q     <= hex_d;
    end
  end

  assign bus.HEX       = hex_q;
  assign bus.busy      = (state_q == ST_CONV);
  assign bus.done      = (state_q == ST_DONE);
  assign bus.overflow  = ovf_out_q;
  assign bus.state_dbg = state_q;

endmodule
